// File: rtl/pc_stack_unit.sv
// Program-counter unit with PC-relative branch and a call/return stack.
// Define PC_STACK_GUARD_EN to suppress stack overflow/underflow and flag them on stk_err.
module pc_stack_unit #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load,
  input  logic                         inc,
  input  logic                         rel,
  input  logic                         call,
  input  logic                         ret,
  input  logic                         err_clr,
  input  logic [WIDTH-1:0]             target,
  input  logic [WIDTH-1:0]             offset,
  output logic [WIDTH-1:0]             pc_out,
  output logic [$clog2(DEPTH+1)-1:0]   sp,
  output logic                         stack_empty,
  output logic                         stack_full,
  output logic                         stk_err
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SP_W-1:0]         SP_FULL = SP_W'(DEPTH);
  localparam logic signed [WIDTH-1:0] ONE     = WIDTH'(1);

  // All PC arithmetic wraps modulo 2^WIDTH; the carry out is dropped.
  function automatic logic [WIDTH-1:0] wrap_add(input logic [WIDTH-1:0] a,
                                                input logic signed [WIDTH-1:0] b);
    wrap_add = a + $unsigned(b);
  endfunction

  logic [WIDTH-1:0]        stack_mem [DEPTH];
  logic signed [WIDTH-1:0] offset_s;
  logic [WIDTH-1:0]        ret_addr;
  logic [IDX_W-1:0]        push_idx;
  logic [IDX_W-1:0]        top_idx;

  assign offset_s    = offset;
  assign ret_addr    = wrap_add(pc_out, ONE);
  assign push_idx    = IDX_W'(sp);
  assign top_idx     = IDX_W'(sp - SP_W'(1));
  assign stack_full  = (sp == SP_FULL);
  assign stack_empty = (sp == '0);

  // Control state: one command per cycle, call > ret > load > rel > inc.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_out <= WIDTH'(RESET_PC);
      sp     <= '0;
    end else if (call) begin
      if (!stack_full) begin
        pc_out <= target;
        sp     <= sp + SP_W'(1);
      end
`ifndef PC_STACK_GUARD_EN
      else begin
        pc_out <= target;
      end
`endif
    end else if (ret) begin
      if (!stack_empty) begin
        pc_out <= stack_mem[top_idx];
        sp     <= sp - SP_W'(1);
      end
    end else if (load) begin
      pc_out <= target;
    end else if (rel) begin
      pc_out <= wrap_add(pc_out, offset_s);
    end else if (inc) begin
      pc_out <= wrap_add(pc_out, ONE);
    end
  end

  // Return-address storage carries no reset; entries above sp are never read.
  always_ff @(posedge clk) begin
    if (call) begin
      if (!stack_full) begin
        stack_mem[push_idx] <= ret_addr;
      end
`ifndef PC_STACK_GUARD_EN
      else begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          stack_mem[IDX_W'(i)] <= stack_mem[IDX_W'(i + 1)];
        end
        stack_mem[IDX_W'(DEPTH - 1)] <= ret_addr;
      end
`endif
    end
  end

`ifdef PC_STACK_GUARD_EN
  logic fault;
  assign fault = (call & stack_full) | (~call & ret & stack_empty);

  // A fault in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stk_err <= 1'b0;
    end else if (fault) begin
      stk_err <= 1'b1;
    end else if (err_clr) begin
      stk_err <= 1'b0;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign stk_err        = 1'b0;
`endif

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Parametrised program-counter unit for the Ahmes CPU; successor to the single 8-bit counter.
- Adds configurable address width, a PC-relative branch, and a hardware call/return stack with occupancy flags.
- Sits between the control FSM and the memory address mux; pc_out drives the instruction-fetch address.

Parameters:
- WIDTH, 8: address width in bits for pc_out, target, offset and stack entries.
- DEPTH, 4: number of return-address stack entries; must be at least 2.
- RESET_PC, 0: value loaded into pc_out on reset.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; forces reset state immediately.
- load  input  1  absolute jump: pc_out <= target.
- inc  input  1  sequential advance: pc_out <= pc_out + 1.
- rel  input  1  relative branch: pc_out <= pc_out + signed offset.
- call  input  1  push pc_out+1, then pc_out <= target.
- ret  input  1  pop the top entry into pc_out.
- err_clr  input  1  clears stk_err.
- target  input  WIDTH  jump/call destination.
- offset  input  WIDTH  two's-complement branch displacement.
- pc_out  output  WIDTH  current program counter.
- sp  output  $clog2(DEPTH+1)  stack occupancy, 0 to DEPTH.
- stack_empty  output  1  asserted when sp==0.
- stack_full  output  1  asserted when sp==DEPTH.
- stk_err  output  1  sticky stack-fault flag.

Behaviour:
- Reset (asynchronous, any cycle, including mid-operation):
  - pc_out=RESET_PC, sp=0, stk_err=0.
  - Stack entry contents are don't-care.
- Command priority: one command acts per cycle, in the order call > ret > load > rel > inc. Lower-priority strobes asserted in the same cycle are ignored.
- No strobe asserted: pc_out and the stack hold.
- Latency: every update is visible on pc_out one clock after the strobe cycle. sp, stack_full and stack_empty are registered or derived from the registered sp.
- Arithmetic:
  - All adds are WIDTH bits and wrap modulo 2^WIDTH, with no carry out. Examples: 8'hFF+1=8'h00; 8'h02+8'hFD=8'hFF.
  - The return address pushed on call is pc_out+1, also wrapped.
- Stack organisation:
  - LIFO with entries 0..DEPTH-1; the top of stack is entry sp-1.
  - call with sp<DEPTH: write entry[sp], sp+1, pc_out<=target.
  - ret with sp>0: pc_out<=entry[sp-1], sp-1.
- Boundary conditions (call on full, ret on empty) are defined under Optional Feature.
- err_clr: clears stk_err the following cycle. A new fault in the same cycle takes precedence: set wins over clear.
- stack_full and stack_empty are mutually exclusive because DEPTH>=2.

Optional Feature:
- Macro: PC_STACK_GUARD_EN.
- Defined (guarded):
  - call on full: the whole command is suppressed; pc_out and the stack hold, and stk_err sets.
  - ret on empty: suppressed; pc_out holds and stk_err sets.
  - Lower-priority strobes asserted in the same cycle still do not act.
- Undefined (circular):
  - call on full: the oldest entry is discarded, the remaining entries shift down one, and the new return address is written at entry DEPTH-1. sp stays at DEPTH and pc_out<=target.
  - ret on empty: pc_out holds and sp stays 0.
  - stk_err is tied to 0 and err_clr is ignored.

Test Plan:
- Reset, then inc for 3 cycles; then load target=8'hF0 and 16 more inc cycles. Required: pc_out reads 0,1,2,3, then 8'hF0, and finally wraps to 8'h00.
- pc_out=8'h10; rel with offset=8'hFC, then rel with offset=8'h05. Required: pc_out=8'h0C, then 8'h11.
- pc_out=8'h20; call target=8'h80 followed by ret. Required: pc_out=8'h80 with sp=1, then pc_out=8'h21 with sp=0 and stack_empty=1.
- Four nested calls from pc values 0x00, 0x10, 0x20 and 0x30 (DEPTH=4). Required: stack_full=1. Then 4 rets: pc_out reads 0x31, 0x21, 0x11, 0x01.
- Fifth call while full:
  - With the macro: pc_out unchanged, stk_err=1; err_clr then drops it.
  - Without the macro: pc_out=target, and the subsequent rets return 0x41, 0x31, 0x21, 0x11.
- call, load and inc asserted together, followed by reset asserted between clock edges. Required: only the call acts; then pc_out=RESET_PC and sp=0 immediately, without waiting for a clock edge.
